// File: rtl/fifo_sample_reader_pkg.sv
// Shared types for the FIFO drain side of the audio path.
// State encoding and default sample width.
package fifo_sample_reader_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: one-cycle tick every CLK_DIV clocks.
// Held at zero while disabled so a restart is a full period.
module sample_tick_gen #(
    parameter int unsigned CLK_DIV = 2268
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    assign o_tick = i_enable && (div_q == LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        if (!i_enable || o_tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/fifo_sample_reader.sv
// Drains one sample per tick from the mixer FIFO to the DAC.
// Underflow repeats the last sample or sends silence.
module fifo_sample_reader
    import fifo_sample_reader_pkg::*;
#(
    parameter int unsigned data_width = DATA_WIDTH,
    parameter int unsigned clk_div    = 2268,
    parameter bit          hold_last  = 1'b1,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [data_width-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic [data_width-1:0] o_sample,
    output logic                  o_sample_valid,
    input  logic                  i_dac_ready,
    output logic                  o_underflow,
    output logic [cnt_width-1:0]  o_underflow_cnt,
    output logic [cnt_width-1:0]  o_overrun_cnt
);

    logic tick;

    state_e                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [data_width-1:0] sample_q, sample_d;
    logic [data_width-1:0] last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  unf_q, unf_d;
    logic [cnt_width-1:0]  unf_cnt_q, unf_cnt_d;
    logic [cnt_width-1:0]  ovr_cnt_q, ovr_cnt_d;

    sample_tick_gen #(
        .CLK_DIV(clk_div)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_enable(i_enable),
        .o_tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        sample_d  = sample_q;
        last_d    = last_q;
        valid_d   = valid_q;
        unf_d     = 1'b0;
        unf_cnt_d = unf_cnt_q;
        ovr_cnt_d = ovr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tick && !i_fifo_empty) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                end else if (tick) begin
                    state_d  = OUTPUT;
                    sample_d = hold_last ? last_q : '0;
                    valid_d  = 1'b1;
                    unf_d    = 1'b1;
                    if (unf_cnt_q != '1) begin
                        unf_cnt_d = unf_cnt_q + 1'b1;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                sample_d = i_fifo_data;
                last_d   = i_fifo_data;
                valid_d  = 1'b1;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                if (i_dac_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A tick that finds the sequencer busy is lost, not queued.
        if (tick && state_q != IDLE && ovr_cnt_q != '1) begin
            ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            sample_q  <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
            unf_q     <= 1'b0;
            unf_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            sample_q  <= sample_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            unf_q     <= unf_d;
            unf_cnt_q <= unf_cnt_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign o_fifo_rd_en    = rd_en_q;
    assign o_sample        = sample_q;
    assign o_sample_valid  = valid_q;
    assign o_underflow     = unf_q;
    assign o_underflow_cnt = unf_cnt_q;
    assign o_overrun_cnt   = ovr_cnt_q;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Randomised bench: two readers (hold/zero policy) share one FIFO,
// a transaction model predicts events, a monitor scores samples.
module tb_fifo_sample_reader;

    localparam int DW   = 16;
    localparam int CDIV = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] s1;
        logic [DW-1:0] s0;
    } exp_t;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          en     = 1'b1;
    logic          ready  = 1'b1;
    logic          fempty = 1'b1;
    logic [DW-1:0] fdata  = '0;

    logic          a_rd, a_va, a_unf, b_rd, b_va, b_unf;
    logic [DW-1:0] a_s, b_s;
    logic [CW-1:0] a_uc, a_oc, b_uc, b_oc;

    logic [DW-1:0] fq[$];
    exp_t          expq[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sample_reader #(
        .data_width(DW), .clk_div(CDIV), .hold_last(1'b1), .cnt_width(CW)
    ) dut_a (
        .clk(clk), .reset(reset), .i_enable(en),
        .i_fifo_empty(fempty), .i_fifo_data(fdata),
        .o_fifo_rd_en(a_rd), .o_sample(a_s), .o_sample_valid(a_va),
        .i_dac_ready(ready), .o_underflow(a_unf),
        .o_underflow_cnt(a_uc), .o_overrun_cnt(a_oc)
    );

    fifo_sample_reader #(
        .data_width(DW), .clk_div(CDIV), .hold_last(1'b0), .cnt_width(CW)
    ) dut_b (
        .clk(clk), .reset(reset), .i_enable(en),
        .i_fifo_empty(fempty), .i_fifo_data(fdata),
        .o_fifo_rd_en(b_rd), .o_sample(b_s), .o_sample_valid(b_va),
        .i_dac_ready(ready), .o_underflow(b_unf),
        .o_underflow_cnt(b_uc), .o_overrun_cnt(b_oc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        fempty = 1'b0;
    endtask

    // Waits (bounded) for rd_en (0), underflow (1) or valid (2).
    task automatic wait_sig(input int which, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            step(1);
            n++;
            case (which)
                0:       hit = a_rd;
                1:       hit = a_unf;
                default: hit = a_va;
            endcase
        end
        if (!hit) chk("wait_timeout", which, 32'hFFFF);
    endtask

    // Reference model: sample-period clock, busy flag, latency countdown.
    int            m_cnt = 0, m_ctv = 0, m_uc = 0, m_oc = 0;
    logic          m_busy = 0, m_v = 0, m_rd = 0, m_unf = 0;
    logic [DW-1:0] m_last = '0;

    always @(negedge clk) begin
        logic tick, hs, nv;
        exp_t e;
        if (!reset) begin
            m_cnt = 0; m_ctv = 0; m_uc = 0; m_oc = 0;
            m_busy = 0; m_v = 0; m_rd = 0; m_unf = 0; m_last = '0;
            expq.delete();
            chk("rst_outs_a", {a_rd, a_va, a_unf, a_s, a_uc, a_oc}, 0);
            chk("rst_outs_b", {b_rd, b_va, b_unf, b_s, b_uc, b_oc}, 0);
        end else begin
            chk("rd_en_a", a_rd, m_rd);
            chk("rd_en_b", b_rd, m_rd);
            chk("underflow_a", a_unf, m_unf);
            chk("underflow_b", b_unf, m_unf);
            chk("valid_a", a_va, m_v);
            chk("valid_b", b_va, m_v);
            chk("unf_cnt_a", a_uc, m_uc);
            chk("unf_cnt_b", b_uc, m_uc);
            chk("ovr_cnt_a", a_oc, m_oc);
            chk("ovr_cnt_b", b_oc, m_oc);
            if (a_rd && fq.size() > 0) fdata = fq.pop_front();
            fempty = (fq.size() == 0);
            tick = en && (m_cnt == CDIV - 1);
            m_cnt = (!en || tick) ? 0 : m_cnt + 1;
            hs = m_v && ready;
            nv = m_v;
            m_rd = 0;
            m_unf = 0;
            if (m_ctv > 0) begin
                m_ctv--;
                if (m_ctv == 0) nv = 1;
            end
            if (tick && m_busy) begin
                if (m_oc < CMAX) m_oc++;
            end else if (tick && fempty) begin
                m_busy = 1; nv = 1; m_unf = 1;
                if (m_uc < CMAX) m_uc++;
                e.s1 = m_last;
                e.s0 = '0;
                expq.push_back(e);
            end else if (tick) begin
                m_busy = 1; m_rd = 1; m_ctv = 2;
                m_last = fq[0];
                e.s1 = fq[0];
                e.s0 = fq[0];
                expq.push_back(e);
            end
            if (hs) begin
                nv = 0;
                m_busy = 0;
            end
            m_v = nv;
        end
    end

    // Scoreboard monitor: scores each accepted sample, checks stability.
    logic          h_v = 0;
    logic [DW-1:0] h_a = '0, h_b = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            h_v = 0;
        end else begin
            if (h_v && a_va) chk("stable_a", a_s, h_a);
            if (h_v && b_va) chk("stable_b", b_s, h_b);
            if (a_va && ready) begin
                if (expq.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("sample_hold1", a_s, e.s1);
                    chk("sample_hold0", b_s, e.s0);
                end
                h_v = 0;
            end else begin
                h_v = a_va;
                h_a = a_s;
                h_b = b_s;
            end
        end
    end

    initial begin
        int n, rdc, o0;
        push(16'h1234);
        push(16'h8001);
        step(3);
        reset = 1'b1;
        push(16'h7FFF);
        wait_sig(0, n);
        chk("first_rd_lat", n, CDIV);
        step(2);
        chk("first_sample", {a_va, a_s}, {1'b1, 16'h1234});

        wait_sig(1, n);
        chk("unf_hold1", a_s, 16'h7FFF);
        chk("unf_hold0", b_s, 16'h0000);
        chk("unf_cnt1", a_uc, 1);
        chk("unf_no_rd", a_rd, 0);

        push(16'h1111);
        push(16'h2222);
        wait_sig(0, n);
        ready = 1'b0;
        o0 = int'(a_oc);
        rdc = 0;
        repeat (20) begin
            step(1);
            rdc += int'(a_rd);
        end
        chk("stall_no_rd", rdc, 0);
        chk("stall_valid", {a_va, a_s}, {1'b1, 16'h1111});
        ready = 1'b1;
        step(2);
        chk("stall_overrun", int'(a_oc) - o0, 2);

        push(16'h3333);
        wait_sig(0, n);
        step(1);
        en = 1'b0;
        wait_sig(2, n);
        step(1);
        rdc = 0;
        repeat (50) begin
            step(1);
            rdc += int'(a_rd) + int'(a_va);
        end
        chk("disabled_quiet", rdc, 0);
        en = 1'b1;
        wait_sig(0, n);
        chk("reenable_lat", n, CDIV);

        step(300 * CDIV + 20);
        chk("unf_sat_a", a_uc, CMAX);
        chk("unf_sat_b", b_uc, CMAX);

        repeat (3000) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) push(DW'($urandom));
            if ($urandom_range(0, 199) == 0) en = ~en;
            step(1);
        end
        en = 1'b1;

        ready = 1'b0;
        wait_sig(2, n);
        reset = 1'b0;
        #1;
        chk("async_valid", {a_va, b_va}, 0);
        chk("async_cnts", {a_uc, a_oc}, 0);
        step(1);
        reset = 1'b1;
        ready = 1'b1;
        push(16'h4444);
        wait_sig(0, n);
        chk("restart_lat", n, CDIV);
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sample_reader.md
Name: fifo_sample_reader

Overview:
- Drain side of the mixed-sample FIFO: pulls one signed sample per audio sample period and presents it to the DAC serializer over a valid/ready handshake.
- Paces reads with an internal sample-rate divider.
- Covers FIFO underflow by repeating the last sample or sending silence.
- Counts underflow and overrun events for debug LEDs.

Parameters:
- data_width, 16, sample width, matching the mixer output.
- clk_div, 2268, clock cycles per sample period (100 MHz / 44.1 kHz); legal range 4 or more.
- hold_last, 1, underflow policy: 1 repeats the last good sample, 0 outputs zero.
- cnt_width, 8, width of the saturating event counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- i_enable  in  1  1 runs the divider and reads; 0 freezes the divider at 0 and forces IDLE after the current handshake.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  data_width  FIFO read data, valid the cycle after o_fifo_rd_en.
- o_fifo_rd_en  out  1  one-cycle FIFO read strobe.
- o_sample  out  data_width  signed sample to the DAC serializer.
- o_sample_valid  out  1  sample valid; held until accepted.
- i_dac_ready  in  1  serializer accepts o_sample when valid and ready are both high.
- o_underflow  out  1  one-cycle pulse per underflowed sample period.
- o_underflow_cnt  out  cnt_width  saturating underflow count.
- o_overrun_cnt  out  cnt_width  saturating count of ticks dropped because the DAC stalled.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, last-sample register 0, divider 0, state IDLE.
- Divider:
  - r_div counts 0..clk_div-1 while i_enable=1.
  - tick is high in the cycle r_div==clk_div-1, then r_div wraps to 0.
- State machine, all outputs registered:
  - IDLE, tick and !i_fifo_empty: next READ; o_fifo_rd_en=1 during READ only.
  - IDLE, tick and i_fifo_empty: next OUTPUT.
    - o_sample is last sample (hold_last=1) or 0 (hold_last=0).
    - o_underflow pulses 1 cycle.
    - o_underflow_cnt increments, saturating at all-ones.
    - No read strobe.
  - READ -> CAPTURE, unconditional.
  - CAPTURE: latch i_fifo_data into o_sample and the last-sample register; next OUTPUT.
  - OUTPUT: o_sample_valid=1. When i_dac_ready=1 in a cycle, valid drops next cycle and state returns to IDLE.
- Latency:
  - tick in cycle T gives rd_en in T+1, data capture at the end of T+2, and valid from T+3.
  - Underflow path: valid from T+1.
- Handshake rules:
  - o_sample is stable while o_sample_valid=1.
  - At most one sample is presented per tick.
  - At most one rd_en is issued per tick.
- Tick while not in IDLE (READ, CAPTURE or OUTPUT): the tick is dropped and o_overrun_cnt increments, saturating. No queued read.
- i_dac_ready=1 while valid=0 is ignored.
- i_fifo_empty is sampled only on the tick in IDLE; empty rising during READ is ignored, because the FIFO has already committed the data.
- i_enable falling:
  - An in-flight READ/CAPTURE/OUTPUT sequence completes normally.
  - Afterwards no new ticks occur.
  - Counters hold their values.
- Reset mid-handshake: valid drops immediately; counters clear.
- Arithmetic: none on sample data, which passes bit-exact.

Decomposition:
- Shared package holds:
  - the state encoding IDLE=0, READ=1, CAPTURE=2, OUTPUT=3 as 2-bit constants;
  - data_width default 16.
- One natural sub-module: sample_tick_gen, the clk_div divider with enable and tick output, reusable by the DAC serializer.
- Saturating counters stay inline.

Test Plan:
- Reset: clk_div=8, FIFO preloaded with 0x1234, 0x8001, reset held low for 3 cycles, then released.
  - All outputs are 0 during reset.
  - First rd_en occurs 8 cycles after release.
  - o_sample=0x1234 with valid high at tick+3.
  - Second sample is 0x8001, bit-exact negative.
- Underflow, hold_last=1: FIFO empty after 0x7FFF is consumed.
  - Next tick gives o_sample=0x7FFF, o_underflow pulse, o_underflow_cnt=1, and no rd_en.
  - Same scenario with hold_last=0: o_sample=0x0000.
- DAC stall: i_dac_ready held 0 for 20 cycles with clk_div=8.
  - o_sample stays valid and stable.
  - o_overrun_cnt=2.
  - Exactly one rd_en is issued; the sample is accepted when ready rises.
- Saturation: cnt_width=8, 300 consecutive underflow ticks.
  - o_underflow_cnt stops at 255.
  - o_underflow pulses continue once per tick.
- Enable drop: i_enable falls during the CAPTURE cycle.
  - Sample is still presented and accepted.
  - Then no further rd_en or valid for 50 cycles.
  - Re-enable gives first tick after 8 cycles.
- Async reset mid-OUTPUT: reset pulsed low for 1 cycle while valid=1.
  - o_sample_valid goes 0 immediately, without waiting for a clock edge.
  - Counters read 0.
  - State restarts cleanly in IDLE.
